// File: rtl/riscv_id_operand.sv
// Decode-stage operand unit: captures RF read data, forwards from EX/MEM/WB,
// detects load-use hazards and registers resolved operands into ID/EX.
module riscv_id_operand #(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pd_valid_i,
    input  logic            pd_stall_i,
    input  logic [AW-1:0]   pd_rs1_i,
    input  logic [AW-1:0]   pd_rs2_i,
    input  logic [XLEN-1:0] rf_src1_q_o,
    input  logic [XLEN-1:0] rf_src2_q_o,
    input  logic            ex_we_i,
    input  logic [AW-1:0]   ex_rd_i,
    input  logic            ex_is_load_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic            mem_we_i,
    input  logic [AW-1:0]   mem_rd_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic            rf_we_i,
    input  logic [AW-1:0]   rf_dst_i,
    input  logic [XLEN-1:0] rf_dst_d_i,
    input  logic            ex_stall_i,
    input  logic            flush_i,
    output logic            id_stall_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_op1_o,
    output logic [XLEN-1:0] ex_op2_o
);

    // Flow control: an instruction advances from pre-decode into ID only when
    // nobody stalls (pd_stall_i, id_stall_o, ex_stall_i all low); a stalled
    // stage holds its contents and the upstream stage must keep presenting.
    logic            id_valid_q;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic            bp_valid_q;
    logic [AW-1:0]   bp_rd_q;
    logic [XLEN-1:0] bp_data_q;
    logic            capture;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign capture = ~pd_stall_i & ~id_stall_o & ~ex_stall_i;

    assign id_stall_o = id_valid_q & ex_is_load_i & ex_we_i & (ex_rd_i != '0)
                      & ((ex_rd_i == rs1_q) | (ex_rd_i == rs2_q));

    // A load match in EX yields ex_result_i here; id_stall_o bubbles it anyway.
    function automatic logic [XLEN-1:0] resolve(input logic [AW-1:0]   rs,
                                                 input logic [XLEN-1:0] rf_q);
        logic [XLEN-1:0] r;
        r = rf_q;
        if (rs == '0)
            r = '0;
        else if (ex_we_i && ex_rd_i == rs)
            r = ex_result_i;
        else if (mem_we_i && mem_rd_i == rs)
            r = mem_result_i;
        else if (rf_we_i && rf_dst_i == rs)
            r = rf_dst_d_i;
        else if (WB_BYPASS && bp_valid_q && bp_rd_q == rs)
            r = bp_data_q;
        return r;
    endfunction

    always_comb begin
        op1 = resolve(rs1_q, rf_src1_q_o);
        op2 = resolve(rs2_q, rf_src2_q_o);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            if (capture) begin
                rs1_q <= pd_rs1_i;
                rs2_q <= pd_rs2_i;
            end
            if (flush_i)
                id_valid_q <= 1'b0;
            else if (capture)
                id_valid_q <= pd_valid_i;
        end
    end

    // Remembers the WB write that raced the RF read so a read-first RF is covered.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_valid_q <= 1'b0;
            bp_rd_q    <= '0;
            bp_data_q  <= '0;
        end else if (capture) begin
            bp_valid_q <= WB_BYPASS && rf_we_i && (rf_dst_i != '0);
            bp_rd_q    <= rf_dst_i;
            bp_data_q  <= rf_dst_d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            ex_valid_o <= 1'b0;
            ex_op1_o   <= '0;
            ex_op2_o   <= '0;
        end else if (!ex_stall_i) begin
            if (id_stall_o) begin
                ex_valid_o <= 1'b0;
                ex_op1_o   <= '0;
                ex_op2_o   <= '0;
            end else begin
                ex_valid_o <= id_valid_q;
                ex_op1_o   <= op1;
                ex_op2_o   <= op2;
            end
        end
    end

endmodule
